// File: rtl/fp_result_checker.sv
// FP result checker: scoreboard of expected FPU results against returned results.
// Expected entries queue in issue order; each returned result is compared against the oldest entry.
module fp_result_checker #(
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 32,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       exp_valid,
  output logic                       exp_ready,
  input  logic [63:0]                exp_result,
  input  logic [4:0]                 exp_flags,
  input  logic [1:0]                 exp_fmt,
  input  logic                       exp_nan_chk,
  input  logic                       dut_ready,
  input  logic [63:0]                dut_result,
  input  logic [4:0]                 dut_flags,
  output logic [$clog2(DEPTH):0]     pending,
  output logic [CNT_W-1:0]           pass_cnt,
  output logic [CNT_W-1:0]           fail_cnt,
  output logic                       fail,
  output logic                       err_under,
  output logic [63:0]                fail_ref_result,
  output logic [63:0]                fail_calc_result,
  output logic [4:0]                 fail_ref_flags,
  output logic [4:0]                 fail_calc_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {
    S_RUN,
    S_FAIL
  } state_t;

  state_t         state;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  logic [63:0]    mem_res [DEPTH];
  logic [4:0]     mem_flg [DEPTH];
  logic [1:0]     mem_fmt [DEPTH];
  logic           mem_nan [DEPTH];

  logic           running;
  logic           empty;
  logic           push;
  logic           pop;
  logic           under;

  logic [63:0]    h_res;
  logic [4:0]     h_flg;
  logic [1:0]     h_fmt;
  logic           h_nan;
  logic           is_sgl;
  logic           is_dbl;
  logic           res_ok;
  logic           match;

  assign running   = (state == S_RUN);
  assign empty     = (pending == '0);
  assign exp_ready = reset && running
                   && (pending != PW'(DEPTH));
  assign push      = exp_valid && exp_ready;
  assign pop       = running && dut_ready && !empty;
  assign under     = running && dut_ready && empty;

  // Head-of-queue compare, with relaxed canonical-NaN match where allowed.
  always_comb begin
    h_res  = mem_res[rd_ptr];
    h_flg  = mem_flg[rd_ptr];
    h_fmt  = mem_fmt[rd_ptr];
    h_nan  = mem_nan[rd_ptr];
    is_sgl = (h_fmt == 2'd0);
    is_dbl = (h_fmt == 2'd1);
    res_ok = 1'b0;
    unique case (1'b1)
      is_sgl: begin
        if (h_nan && dut_result[31:0] == 32'h7FC0_0000)
          res_ok = (h_res[30:22] == dut_result[30:22]);
        else
          res_ok = (h_res[31:0] == dut_result[31:0]);
      end
      is_dbl: begin
        if (h_nan && dut_result == 64'h7FF8_0000_0000_0000)
          res_ok = (h_res[62:51] == dut_result[62:51]);
        else
          res_ok = (h_res == dut_result);
      end
      default: res_ok = (h_res == dut_result);
    endcase
    match = res_ok && (h_flg == dut_flags);
  end

  // Entry storage; data needs no reset since occupancy tracks validity.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_res[wr_ptr] <= exp_result;
      mem_flg[wr_ptr] <= exp_flags;
      mem_fmt[wr_ptr] <= exp_fmt;
      mem_nan[wr_ptr] <= exp_nan_chk;
    end
  end

  // Queue control, counters, sticky status, first-failure capture and run/fail state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= S_RUN;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      pending          <= '0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      fail             <= 1'b0;
      err_under        <= 1'b0;
      fail_ref_result  <= '0;
      fail_calc_result <= '0;
      fail_ref_flags   <= '0;
      fail_calc_flags  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        pending <= pending + 1'b1;
      else if (pop && !push)
        pending <= pending - 1'b1;
      if (under)
        err_under <= 1'b1;
      if (pop) begin
        if (match) begin
          if (pass_cnt != '1)
            pass_cnt <= pass_cnt + 1'b1;
        end else begin
          if (fail_cnt != '1)
            fail_cnt <= fail_cnt + 1'b1;
          fail <= 1'b1;
          if (!fail) begin
            fail_ref_result  <= h_res;
            fail_calc_result <= dut_result;
            fail_ref_flags   <= h_flg;
            fail_calc_flags  <= dut_flags;
          end
          if (STOP_ON_FAIL != 0)
            state <= S_FAIL;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_result_checker.sv
// Bench for fp_result_checker: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fp_result_checker;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        exp_valid;
  logic [63:0] exp_result;
  logic [4:0]  exp_flags;
  logic [1:0]  exp_fmt;
  logic        exp_nan_chk;
  logic        dut_ready;
  logic [63:0] dut_result;
  logic [4:0]  dut_flags;

  logic        a_rdy, b_rdy;
  logic [3:0]  a_pend, b_pend;
  logic [31:0] a_pc, a_fc;
  logic [3:0]  b_pc, b_fc;
  logic        a_fail, b_fail, a_und, b_und;
  logic [63:0] a_rr, a_cr, b_rr, b_cr;
  logic [4:0]  a_rf, a_cf, b_rf, b_cf;

  int n_pass = 0;
  int n_total = 0;
  bit chk_on = 0;

  always #5 clock = ~clock;

  fp_result_checker #(.DEPTH(DEPTH), .CNT_W(32), .STOP_ON_FAIL(1)) dut_a (
    .clock(clock), .reset(reset),
    .exp_valid(exp_valid), .exp_ready(a_rdy),
    .exp_result(exp_result), .exp_flags(exp_flags),
    .exp_fmt(exp_fmt), .exp_nan_chk(exp_nan_chk),
    .dut_ready(dut_ready), .dut_result(dut_result), .dut_flags(dut_flags),
    .pending(a_pend), .pass_cnt(a_pc), .fail_cnt(a_fc),
    .fail(a_fail), .err_under(a_und),
    .fail_ref_result(a_rr), .fail_calc_result(a_cr),
    .fail_ref_flags(a_rf), .fail_calc_flags(a_cf)
  );

  fp_result_checker #(.DEPTH(DEPTH), .CNT_W(4), .STOP_ON_FAIL(0)) dut_b (
    .clock(clock), .reset(reset),
    .exp_valid(exp_valid), .exp_ready(b_rdy),
    .exp_result(exp_result), .exp_flags(exp_flags),
    .exp_fmt(exp_fmt), .exp_nan_chk(exp_nan_chk),
    .dut_ready(dut_ready), .dut_result(dut_result), .dut_flags(dut_flags),
    .pending(b_pend), .pass_cnt(b_pc), .fail_cnt(b_fc),
    .fail(b_fail), .err_under(b_und),
    .fail_ref_result(b_rr), .fail_calc_result(b_cr),
    .fail_ref_flags(b_rf), .fail_calc_flags(b_cf)
  );

  typedef struct {
    logic [63:0] r;
    logic [4:0]  f;
    logic [1:0]  fmt;
    logic        nan;
  } ent_t;

  typedef struct {
    longint      pc;
    longint      fc;
    bit          fl;
    bit          un;
    bit          st;
    logic [63:0] rr;
    logic [63:0] cr;
    logic [4:0]  rf;
    logic [4:0]  cf;
  } mdl_t;

  ent_t qa[$];
  ent_t qb[$];
  mdl_t m[2];

  function automatic int qsz(int k);
    return (k == 0) ? qa.size() : qb.size();
  endfunction

  function automatic bit ref_match(ent_t e, logic [63:0] r, logic [4:0] f);
    bit ok;
    if (e.fmt == 2'd0) begin
      if (e.nan && r[31:0] == 32'h7FC0_0000) ok = (e.r[30:22] == r[30:22]);
      else ok = (e.r[31:0] == r[31:0]);
    end else if (e.fmt == 2'd1) begin
      if (e.nan && r == 64'h7FF8_0000_0000_0000) ok = (e.r[62:51] == r[62:51]);
      else ok = (e.r == r);
    end else begin
      ok = (e.r == r);
    end
    return ok && (e.f == f);
  endfunction

  function automatic void step(int k, bit stop, longint cmax);
    ent_t h;
    ent_t e;
    int   n;
    if (!reset) begin
      if (k == 0) qa.delete(); else qb.delete();
      m[k].pc = 0; m[k].fc = 0;
      m[k].fl = 0; m[k].un = 0; m[k].st = 0;
      m[k].rr = 0; m[k].cr = 0; m[k].rf = 0; m[k].cf = 0;
      return;
    end
    if (m[k].st) return;
    n = qsz(k);
    if (dut_ready && n == 0) m[k].un = 1;
    if (dut_ready && n > 0) begin
      if (k == 0) h = qa.pop_front(); else h = qb.pop_front();
      if (ref_match(h, dut_result, dut_flags)) begin
        if (m[k].pc < cmax) m[k].pc++;
      end else begin
        if (m[k].fc < cmax) m[k].fc++;
        if (!m[k].fl) begin
          m[k].rr = h.r; m[k].cr = dut_result;
          m[k].rf = h.f; m[k].cf = dut_flags;
        end
        m[k].fl = 1;
        if (stop) m[k].st = 1;
      end
    end
    if (exp_valid && n < DEPTH) begin
      e.r = exp_result; e.f = exp_flags;
      e.fmt = exp_fmt; e.nan = exp_nan_chk;
      if (k == 0) qa.push_back(e); else qb.push_back(e);
    end
  endfunction

  // Reference model advances on the same edge as the DUTs.
  always @(posedge clock) begin
    step(0, 1'b1, 64'hFFFF_FFFF);
    step(1, 1'b0, 15);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic cmp(input int k, input logic [63:0] pend, input logic [63:0] rdy,
                     input logic [63:0] pc, input logic [63:0] fc,
                     input logic [63:0] fl, input logic [63:0] un,
                     input logic [63:0] rr, input logic [63:0] cr,
                     input logic [63:0] rf, input logic [63:0] cf);
    string p;
    p = (k == 0) ? "A" : "B";
    chk({p, ".pending"}, pend, 64'(qsz(k)));
    chk({p, ".exp_ready"}, rdy, 64'(reset && qsz(k) < DEPTH && !m[k].st));
    chk({p, ".pass_cnt"}, pc, 64'(m[k].pc));
    chk({p, ".fail_cnt"}, fc, 64'(m[k].fc));
    chk({p, ".fail"}, fl, 64'(m[k].fl));
    chk({p, ".err_under"}, un, 64'(m[k].un));
    chk({p, ".ref_result"}, rr, m[k].rr);
    chk({p, ".calc_result"}, cr, m[k].cr);
    chk({p, ".ref_flags"}, rf, 64'(m[k].rf));
    chk({p, ".calc_flags"}, cf, 64'(m[k].cf));
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      cmp(0, 64'(a_pend), 64'(a_rdy), 64'(a_pc), 64'(a_fc), 64'(a_fail),
          64'(a_und), a_rr, a_cr, 64'(a_rf), 64'(a_cf));
      cmp(1, 64'(b_pend), 64'(b_rdy), 64'(b_pc), 64'(b_fc), 64'(b_fail),
          64'(b_und), b_rr, b_cr, 64'(b_rf), 64'(b_cf));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    exp_valid = 0;
    dut_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  task automatic push_e(input logic [63:0] r, input logic [4:0] f,
                        input logic [1:0] fmt, input logic nan);
    exp_valid = 1; exp_result = r; exp_flags = f;
    exp_fmt = fmt; exp_nan_chk = nan;
    tick();
    exp_valid = 0;
  endtask

  task automatic ret(input logic [63:0] r, input logic [4:0] f);
    dut_ready = 1; dut_result = r; dut_flags = f;
    tick();
    dut_ready = 0;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    ent_t h;
    int pick;
    reset = 0; exp_valid = 0; exp_result = 0; exp_flags = 0;
    exp_fmt = 0; exp_nan_chk = 0;
    dut_ready = 0; dut_result = 0; dut_flags = 0;
    do_reset();
    chk_on = 1;
    @(negedge clock);
    chk("reset.pending", 64'(a_pend), 0);
    chk("reset.exp_ready", 64'(a_rdy), 1);

    // Three double entries, results return with varying latency.
    do_reset();
    push_e(64'h3FF0_0000_0000_0000, 5'h00, 2'd1, 1'b1);
    push_e(64'h4000_0000_0000_0000, 5'h01, 2'd1, 1'b1);
    push_e(64'hC008_0000_0000_0000, 5'h10, 2'd1, 1'b1);
    wait_n(1);
    ret(64'h3FF0_0000_0000_0000, 5'h00);
    wait_n(2);
    ret(64'h4000_0000_0000_0000, 5'h01);
    wait_n(3);
    ret(64'hC008_0000_0000_0000, 5'h10);
    @(negedge clock);
    chk("lat.pass_cnt", 64'(a_pc), 3);
    chk("lat.fail_cnt", 64'(a_fc), 0);
    chk("lat.pending", 64'(a_pend), 0);

    // Relaxed canonical-NaN compare, then the same without relaxation.
    do_reset();
    push_e(64'h7FC1_2345, 5'h00, 2'd0, 1'b1);
    ret(64'h7FC0_0000, 5'h00);
    @(negedge clock);
    chk("nan.pass_cnt", 64'(a_pc), 1);
    push_e(64'h7FC1_2345, 5'h00, 2'd0, 1'b0);
    ret(64'h7FC0_0000, 5'h00);
    @(negedge clock);
    chk("nan.fail", 64'(a_fail), 1);
    chk("nan.fail_cnt", 64'(a_fc), 1);
    chk("nan.ref_result", a_rr, 64'h7FC1_2345);
    chk("nan.calc_result", a_cr, 64'h7FC0_0000);

    // Full queue: ready drops, pop frees a slot, order is kept.
    do_reset();
    for (int i = 0; i < 8; i++) push_e(64'(i), 5'h00, 2'd2, 1'b0);
    @(negedge clock);
    chk("full.pending", 64'(a_pend), 8);
    chk("full.exp_ready", 64'(a_rdy), 0);
    exp_valid = 1; exp_result = 64'd100; exp_flags = 0; exp_fmt = 2'd2;
    ret(64'd0, 5'h00);
    exp_valid = 0;
    @(negedge clock);
    chk("full.pend_after_pop", 64'(a_pend), 7);
    push_e(64'd100, 5'h00, 2'd2, 1'b0);
    @(negedge clock);
    chk("full.pend_refill", 64'(a_pend), 8);
    for (int i = 1; i < 8; i++) ret(64'(i), 5'h00);
    ret(64'd100, 5'h00);
    @(negedge clock);
    chk("full.pass_cnt", 64'(a_pc), 9);
    chk("full.fail_cnt", 64'(a_fc), 0);

    // Flag mismatch on the 2nd of 4 results stops the checker.
    do_reset();
    push_e(64'h11, 5'h00, 2'd2, 1'b0);
    push_e(64'h22, 5'h01, 2'd2, 1'b0);
    push_e(64'h33, 5'h00, 2'd2, 1'b0);
    push_e(64'h44, 5'h00, 2'd2, 1'b0);
    ret(64'h11, 5'h00);
    ret(64'h22, 5'h00);
    ret(64'h33, 5'h00);
    ret(64'h44, 5'h00);
    @(negedge clock);
    chk("stop.fail", 64'(a_fail), 1);
    chk("stop.pass_cnt", 64'(a_pc), 1);
    chk("stop.fail_cnt", 64'(a_fc), 1);
    chk("stop.exp_ready", 64'(a_rdy), 0);
    chk("stop.pending", 64'(a_pend), 2);
    chk("stop.ref_flags", 64'(a_rf), 1);
    chk("stop.b_pass_cnt", 64'(b_pc), 3);

    // Underflow with a simultaneous push: no bypass.
    do_reset();
    exp_valid = 1; exp_result = 64'h55; exp_flags = 0; exp_fmt = 2'd3;
    ret(64'h55, 5'h00);
    exp_valid = 0;
    @(negedge clock);
    chk("under.err_under", 64'(a_und), 1);
    chk("under.pending", 64'(a_pend), 1);
    chk("under.pass_cnt", 64'(a_pc), 0);

    // Reset while busy and failed.
    do_reset();
    for (int i = 0; i < 6; i++) push_e(64'(i), 5'h00, 2'd2, 1'b0);
    ret(64'd99, 5'h00);
    @(negedge clock);
    chk("rst.pre_pending", 64'(a_pend), 5);
    chk("rst.pre_fail", 64'(a_fail), 1);
    reset = 0;
    tick();
    @(negedge clock);
    chk("rst.pending", 64'(a_pend), 0);
    chk("rst.fail", 64'(a_fail), 0);
    chk("rst.fail_cnt", 64'(a_fc), 0);
    chk("rst.ref_result", a_rr, 0);
    chk("rst.exp_ready", 64'(a_rdy), 0);
    tick();
    reset = 1;
    @(negedge clock);
    chk("rst.exp_ready_rel", 64'(a_rdy), 1);

    // Randomized episodes checked by the model.
    for (int ep = 0; ep < 60; ep++) begin
      do_reset();
      for (int c = 0; c < 100; c++) begin
        reset = ($urandom_range(0, 299) != 0);
        exp_valid = $urandom_range(0, 1);
        exp_fmt = 2'($urandom_range(0, 3));
        exp_nan_chk = $urandom_range(0, 1);
        exp_flags = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00;
        case ($urandom_range(0, 2))
          0: exp_result = {$urandom, $urandom};
          1: exp_result = {$urandom, 32'h7FC0_0000 | 32'($urandom_range(0, 32'h3F_FFFF))};
          default: exp_result = 64'h7FF8_0000_0000_0000 | 64'($urandom);
        endcase
        dut_ready = ($urandom_range(0, 2) == 0);
        dut_result = {$urandom, $urandom};
        dut_flags = 5'($urandom);
        pick = $urandom_range(0, 15);
        if (qb.size() > 0 && pick < 14) begin
          h = qb[0];
          dut_result = h.r;
          dut_flags = h.f;
          if (pick < 4)
            dut_result = (h.fmt == 2'd0) ? {h.r[63:32], 32'h7FC0_0000}
                                         : 64'h7FF8_0000_0000_0000;
          else if (pick == 12)
            dut_result = h.r ^ (64'd1 << $urandom_range(0, 63));
          else if (pick == 13)
            dut_flags = h.f ^ (5'd1 << $urandom_range(0, 4));
        end
        tick();
      end
    end
    idle();
    tick();
    @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
